instruction_fetch_stage: RTL

//   Front pipeline stage: holds the PC and a word-addressed instruction memory,
//   and registers each fetched 32-bit instruction into the IF/ID latch that

---
 rtl/instruction_fetch_stage_if.sv | 27 ++
 rtl/instruction_fetch_stage.sv | 96 +++++++++
 2 files changed

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: control inputs, loader write port and the IF/ID outputs.
interface instruction_fetch_stage_if #(
    parameter int PC_W = 6
);
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_we;
    logic [PC_W-1:0] imem_waddr;
    logic [31:0]     imem_wdata;
    logic [31:0]     ins;
    logic [PC_W-1:0] pc_id;
    logic            ins_valid;
    logic            halted;

    // Pipeline control / loader side
    modport master (
        output stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
        input  ins, pc_id, ins_valid, halted
    );

    // Fetch stage side
    modport slave (
        input  stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
        output ins, pc_id, ins_valid, halted
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, word-addressed instruction memory and the
// IF/ID latch. Supports stall, redirect (flush) and a sticky HALT.
module instruction_fetch_stage #(
    parameter int          DEPTH   = 64,
    parameter int          PC_W    = 6,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic                        clk,
    input  logic                        reset,
    instruction_fetch_stage_if.slave    bus
);
    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    logic [31:0]     mem [DEPTH];

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ins_q, ins_d;
    logic [PC_W-1:0] pc_id_q, pc_id_d;
    logic            valid_q, valid_d;
    logic [31:0]     fetch_word;

    // Combinational read; a same-edge write is not yet visible here, so a
    // fetch colliding with a write returns the old word.
    assign fetch_word = mem[pc_q];

    // Loader write port; memory is intentionally not touched by reset.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // State register for PC, IF/ID latch and run/halt state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            ins_q   <= '0;
            pc_id_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            pc_id_q <= pc_id_d;
            valid_q <= valid_d;
        end
    end

    // Next state: redirect beats halt, halt beats stall, stall beats fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        pc_id_d = pc_id_q;
        valid_d = valid_q;

        if (bus.redirect) begin
            // Flush the latch; pc_id keeps the last delivered address.
            pc_d    = bus.redirect_pc;
            ins_d   = '0;
            valid_d = 1'b0;
            state_d = S_RUN;
        end else begin
            unique case (state_q)
                S_HALT: begin
                    ins_d   = '0;
                    valid_d = 1'b0;
                end
                default: begin
                    if (!bus.stall) begin
                        ins_d   = fetch_word;
                        pc_id_d = pc_q;
                        valid_d = 1'b1;
                        if (fetch_word[31:26] == HALT_OP) begin
                            // HALT itself is delivered; PC parks on it.
                            state_d = S_HALT;
                        end else begin
                            // PC_W-bit add wraps modulo DEPTH.
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ins       = ins_q;
    assign bus.pc_id     = pc_id_q;
    assign bus.ins_valid = valid_q;
    assign bus.halted    = (state_q == S_HALT);
endmodule
